// File: rtl/base_acredit_src.sv
// Credit-based link source: accepts valid/ready beats, launches registered valid-only
// beats toward a credit sink, and tracks free sink slots in a saturating credit counter.
module base_acredit_src #(
  parameter int credits     = 4,
  parameter int log_credits = $clog2(credits + 1),
  parameter int width       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  output logic             i_r,
  input  logic [width-1:0] i_d,
  output logic             o_v,
  output logic [width-1:0] o_d,
  input  logic             o_c,
  output logic             o_idle,
  output logic             o_err
);

  localparam logic [log_credits-1:0] full_cnt = log_credits'(credits);
  localparam logic [log_credits-1:0] one_cnt  = log_credits'(1);

  logic [log_credits-1:0] cnt;
  logic                   acc;
  logic                   full;
  logic                   inc;
  logic                   dec;
  logic                   overflow;

  // Ready depends only on the counter, so a returned credit is never bypassed
  // into the same cycle's accept decision.
  assign i_r      = (cnt != '0);
  assign full     = (cnt == full_cnt);
  assign acc      = i_v & i_r;
  assign inc      = o_c & ~acc & ~full;
  assign dec      = acc & ~o_c;
  assign overflow = o_c & ~acc & full;
  assign o_idle   = full;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= full_cnt;
    end else if (inc) begin
      cnt <= cnt + one_cnt;
    end else if (dec) begin
      cnt <= cnt - one_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_v <= 1'b0;
      o_d <= '0;
    end else begin
      o_v <= acc;
      if (acc) begin
        o_d <= i_d;
      end
    end
  end

  // A credit arriving while all credits are home means the sink returned more than it
  // was given; the counter saturates and the flag latches until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_err <= 1'b0;
    end else if (overflow) begin
      o_err <= 1'b1;
    end
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (!reset) cnt <= full_cnt);
  a_acc_has_credit: assert property (@(posedge clk) disable iff (!reset) acc |-> (cnt != '0));
  a_beat_launch: assert property (@(posedge clk) disable iff (!reset) acc |=> o_v);
  a_err_on_overflow: assert property (@(posedge clk) disable iff (!reset) overflow |=> o_err);
  a_err_sticky: assert property (@(posedge clk) disable iff (!reset) o_err |=> o_err);

endmodule

// File: tb/tb_base_acredit_src.sv
// Directed bench for base_acredit_src (credits=4, width=8) with a behavioural
// depth-4 credit sink for the loopback phase.
module tb_base_acredit_src;
  localparam int credits = 4;
  localparam int width   = 8;

  logic             clk    = 1'b0;
  logic             reset  = 1'b0;
  logic             i_v    = 1'b0;
  logic             i_r;
  logic [width-1:0] i_d    = '0;
  logic             o_v;
  logic [width-1:0] o_d;
  logic             o_c    = 1'b0;
  logic             o_idle;
  logic             o_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [width-1:0] sink_q[$];
  logic [width-1:0] exp_q[$];
  int               max_occ = 0;
  int               n_acc;

  always #5 clk = ~clk;

  base_acredit_src #(
    .credits(credits),
    .width  (width)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .i_v   (i_v),
    .i_r   (i_r),
    .i_d   (i_d),
    .o_v   (o_v),
    .o_d   (o_d),
    .o_c   (o_c),
    .o_idle(o_idle),
    .o_err (o_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One loopback cycle: sink collects launched beat, maybe delivers one and returns
  // a credit, source maybe offers a new beat.
  task automatic lb_step(input bit allow_src);
    logic [width-1:0] got;
    if (o_v) begin
      sink_q.push_back(o_d);
      if (sink_q.size() > max_occ) max_occ = sink_q.size();
    end
    o_c = 1'b0;
    if (sink_q.size() > 0 && (!allow_src || $urandom_range(0, 2) != 0)) begin
      got = sink_q.pop_front();
      if (exp_q.size() == 0) check("lb_extra_beat", 32'(got), 32'hFFFF_FFFF);
      else check("lb_data", 32'(got), 32'(exp_q.pop_front()));
      o_c = 1'b1;
    end
    i_v = allow_src && ($urandom_range(0, 1) == 1);
    i_d = width'($urandom);
    if (i_v && i_r) exp_q.push_back(i_d);
    tick();
  endtask

  initial begin
    @(negedge clk);
    check("rst_o_v", 32'(o_v), 0);
    check("rst_o_d", 32'(o_d), 0);
    check("rst_o_idle", 32'(o_idle), 1);
    check("rst_i_r", 32'(i_r), 1);
    check("rst_o_err", 32'(o_err), 0);
    reset = 1'b1;

    // 1: four beats drain all credits, fifth is held
    i_v = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_d = width'(k);
      check("t1_i_r", 32'(i_r), 1);
      tick();
      check("t1_o_v", 32'(o_v), 1);
      check("t1_o_d", 32'(o_d), 32'(k));
    end
    check("t1_i_r_empty", 32'(i_r), 0);
    check("t1_o_idle", 32'(o_idle), 0);
    i_d = 8'h05;
    tick();
    check("t1_held_o_v", 32'(o_v), 0);
    check("t1_held_o_d", 32'(o_d), 32'h04);
    check("t1_held_i_r", 32'(i_r), 0);
    tick();
    check("t1_held2_o_v", 32'(o_v), 0);

    // 2: one credit releases the held beat
    o_c = 1'b1;
    check("t2_i_r_same_cycle", 32'(i_r), 0);
    tick();
    o_c = 1'b0;
    check("t2_i_r", 32'(i_r), 1);
    check("t2_o_v_pre", 32'(o_v), 0);
    tick();
    check("t2_o_v", 32'(o_v), 1);
    check("t2_o_d", 32'(o_d), 32'h05);
    check("t2_i_r_empty", 32'(i_r), 0);
    i_v = 1'b0;
    o_c = 1'b1;
    tick();
    tick();
    o_c = 1'b0;
    check("t2_cnt2_i_r", 32'(i_r), 1);
    check("t2_cnt2_idle", 32'(o_idle), 0);

    // 3: cnt=2, accept and credit every cycle for 20 cycles
    i_v = 1'b1;
    o_c = 1'b1;
    for (int j = 0; j < 20; j++) begin
      i_d = 8'h10 + width'(j);
      check("t3_i_r", 32'(i_r), 1);
      tick();
      check("t3_o_v", 32'(o_v), 1);
      check("t3_o_d", 32'(o_d), 32'(8'h10 + width'(j)));
    end
    o_c = 1'b0;
    n_acc = 0;
    for (int j = 0; j < 4; j++) begin
      i_d = 8'hA0 + width'(j);
      if (i_r) n_acc++;
      tick();
    end
    check("t3_cnt_still_2", 32'(n_acc), 2);
    i_v = 1'b0;
    tick();
    o_c = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    o_c = 1'b0;
    check("t3_idle", 32'(o_idle), 1);
    check("t3_no_err", 32'(o_err), 0);

    // full counter with accept and credit together is legal
    i_v = 1'b1;
    o_c = 1'b1;
    i_d = 8'h5A;
    tick();
    i_v = 1'b0;
    o_c = 1'b0;
    check("full_acc_crd_o_v", 32'(o_v), 1);
    check("full_acc_crd_o_d", 32'(o_d), 32'h5A);
    check("full_acc_crd_idle", 32'(o_idle), 1);
    check("full_acc_crd_err", 32'(o_err), 0);

    // 4: spurious credit while idle
    o_c = 1'b1;
    tick();
    o_c = 1'b0;
    check("t4_err", 32'(o_err), 1);
    check("t4_idle", 32'(o_idle), 1);
    check("t4_i_r", 32'(i_r), 1);
    for (int j = 0; j < 3; j++) tick();
    check("t4_err_sticky", 32'(o_err), 1);
    check("t4_idle_hold", 32'(o_idle), 1);
    i_v = 1'b1;
    n_acc = 0;
    for (int j = 0; j < 6; j++) begin
      i_d = 8'hE0 + width'(j);
      if (i_r) n_acc++;
      tick();
    end
    i_v = 1'b0;
    check("t4_cnt_saturated", 32'(n_acc), 4);
    check("t4_err_after_drain", 32'(o_err), 1);

    // 5: asynchronous reset with cnt=1 and a beat in the output register
    o_c = 1'b1;
    tick();
    tick();
    o_c = 1'b0;
    i_v = 1'b1;
    i_d = 8'hC3;
    tick();
    i_v = 1'b0;
    check("t5_pre_o_v", 32'(o_v), 1);
    check("t5_pre_o_d", 32'(o_d), 32'hC3);
    check("t5_pre_idle", 32'(o_idle), 0);
    #2 reset = 1'b0;
    #1;
    check("t5_async_o_v", 32'(o_v), 0);
    check("t5_async_o_d", 32'(o_d), 0);
    check("t5_async_idle", 32'(o_idle), 1);
    check("t5_async_i_r", 32'(i_r), 1);
    check("t5_async_err", 32'(o_err), 0);
    @(negedge clk);
    reset = 1'b1;

    // 6: random loopback through a depth-4 credit sink
    for (int cyc = 0; cyc < 400; cyc++) lb_step(1'b1);
    for (int cyc = 0; cyc < 30; cyc++) lb_step(1'b0);
    check("t6_exp_empty", 32'(exp_q.size()), 0);
    check("t6_sink_empty", 32'(sink_q.size()), 0);
    check("t6_max_occ_ok", 32'(max_occ <= credits), 1);
    check("t6_idle", 32'(o_idle), 1);
    check("t6_no_err", 32'(o_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
